avalon_stall_ram: RTL and testbench
===================================

# avalon_stall_ram

Avalon-MM slave word memory that sits directly downstream of the CPU's memory bus master and answers its read/write requests with a programmable number of `waitrequest` stall cycles. It replaces the zero-latency testbench RAM when stress-testing CPU stall handling. It also provides a side-band preload port so benches can write program and data words before or during a run.

## Interface
- `ADDR_W`, 8: word-index width; memory depth is 2**ADDR_W 32-bit words.
- `STALL_CYCLES`, 2: extra wait cycles inserted per transfer (0..15).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  32  byte address from the bus master.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  per-byte write enable; bit0 maps to bits 7:0.
- `waitrequest`  out  1  high while the request is not yet complete.
- `readdata`  out  32  read data, valid in the cycle `waitrequest` is low with `read` high.
- `bus_error`  out  1  one-cycle pulse on a misaligned address or simultaneous read+write.
- `preload_en`  in  1  side-band full-word write enable.
- `preload_addr`  in  ADDR_W  preload word index.
- `preload_data`  in  32  preload word.

## Operation
- Word index is `address[ADDR_W+1:2]`. Upper address bits are ignored, so the memory aliases across the 32-bit space.
- FSM states:
  - IDLE: on `read|write`, latch index, `writedata`, `byteenable` and direction. Load counter = STALL_CYCLES. Go to WAIT if the counter is nonzero, otherwise go to DONE.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to DONE.
  - DONE: transfer completes. Always return to IDLE.
- `waitrequest` is combinational: (`read|write`) AND state != DONE. It is 0 when there is no request.
- Read: on the IDLE/WAIT→DONE edge, `readdata` <= mem[latched index]. `readdata` holds that value until the next read completes.
- Write: commits at the clock edge that ends DONE. Only bytes with `byteenable` set are written. `byteenable`=0000 completes the handshake and writes nothing.
- The master must hold its request stable until it sees `waitrequest`=0. The slave uses only the values latched in IDLE, so later changes to the inputs are ignored.
- `read` and `write` both high in IDLE: the request is treated as a write, and `bus_error` pulses in the following cycle.
- `address[1:0]` != 0 in IDLE: the transfer proceeds with the low bits dropped, and `bus_error` pulses in the following cycle.
- Request dropped during WAIT (protocol violation): the FSM still completes the latched transfer, and `waitrequest` reads 0.
- Preload:
  - Writes the full word at any clock edge, in any state.
  - Same edge and same index as a committing bus write: preload wins and the bus write is discarded.
  - A read latched in the same cycle as a preload to the same index returns the old word.
- Memory is not cleared by reset; contents are X until written.

## Timing
- Reset values: state=IDLE, counter=0, `readdata`=0, `bus_error`=0. `waitrequest` follows its combinational equation, so it is high if a request is present during reset.
- Reset mid-transfer: the transfer is aborted, and a pending write is not committed.
- Latency, request first seen in cycle 0: `waitrequest` is high in cycles 0..STALL_CYCLES and low in cycle STALL_CYCLES+1. That is a total of STALL_CYCLES+2 cycles per transfer.
- Back-to-back transfers: the next request can be accepted in the cycle right after DONE, so there is no idle gap beyond the IDLE acceptance cycle.
- `bus_error` is registered: high exactly one cycle, the cycle after acceptance.

## Test plan
- STALL_CYCLES=2: preload [4]=0x24020010, then read 0x10. Expected: `waitrequest` high for 3 cycles, low for 1, with `readdata`=0x24020010 in that cycle.
- STALL_CYCLES=0: write 0xDEADBEEF to 0x20 with be=1111, then write 0x000000AA with be=0001, then read 0x20. Expected: 0xDEADBEAA, and each transfer takes 2 cycles.
- Read and write both high at 0x08 with writedata 0x70. Expected: `bus_error` pulses once, and a later read of 0x08 returns 0x00000070.
- Read 0x0E (misaligned). Expected: returns the word at index 3, and `bus_error` pulses one cycle.
- Assert `reset` during WAIT of a write to 0x30. Expected: `waitrequest` drops with no request, the word at 0x30 is unchanged, and `readdata`=0.
- Preload [8]=0x11111111 on the same edge that a bus write of 0x22222222 to 0x20 commits. Expected: a read of 0x20 returns 0x11111111.

Source files
------------

// File: rtl/avalon_stall_ram.sv
// avalon_stall_ram
// Avalon-MM slave word memory with a programmable number of waitrequest
// stall cycles per transfer, used to stress a CPU's stall handling. A
// side-band preload port writes whole words at any time.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   address[31:0]              byte address; word index = address[ADDR_W+1:2]
//   read, write                request strobes (held until waitrequest=0)
//   writedata[31:0]            write data
//   byteenable[3:0]            per-byte write enable (bit0 -> bits 7:0)
//   waitrequest                high while a present request is not complete
//   readdata[31:0]             read data, valid when waitrequest=0 with read
//   bus_error                  one-cycle pulse after a misaligned or read+write accept
//   preload_en/addr/data       side-band full-word write
module avalon_stall_ram #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    output logic              bus_error,
    input  logic              preload_en,
    input  logic [ADDR_W-1:0] preload_addr,
    input  logic [31:0]       preload_data
);

    localparam logic [3:0] STALL = 4'(STALL_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                wr_q, wr_d;
    logic                berr_q, berr_d;
    logic [31:0]         rdata_q;
    logic                rd_fire;

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];

    // Upper address bits alias; they are intentionally not decoded.
    logic unused_addr;
    assign unused_addr = ^address[31:ADDR_W+2];

    assign waitrequest = (read | write) && (state_q != DONE);
    assign readdata    = rdata_q;
    assign bus_error   = berr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (read | write) begin
                    idx_d   = address[ADDR_W+1:2];
                    wdata_d = writedata;
                    be_d    = byteenable;
                    wr_d    = write;          // read+write resolves to a write
                    cnt_d   = STALL;
                    berr_d  = (read & write) | (address[1:0] != 2'b00);
                    state_d = (STALL != 4'd0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                // Latched transfer completes even if the master drops its request.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is sampled on the edge entering DONE, using the index that
    // is (or is being) latched.
    assign rd_fire = (state_d == DONE) && (state_q != DONE) && !wr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            berr_q  <= berr_d;
            if (rd_fire) rdata_q <= mem_q[idx_d];
        end
    end

    // Memory is not reset. Bus write commits on the edge leaving DONE; the
    // preload is assigned last so it overrides a same-index bus write.
    // Reset forces state to IDLE, which blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && state_q == DONE && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
        if (preload_en) mem_q[preload_addr] <= preload_data;
    end

endmodule

// File: tb/tb_avalon_stall_ram.sv
module tb_avalon_stall_ram;

    logic        clk = 1'b0;
    logic        reset;

    // DUT with 2 stall cycles
    logic [31:0] addr2, wdata2, rdata2;
    logic        rd2, wr2, wreq2, berr2, pen2;
    logic [3:0]  be2;
    logic [7:0]  paddr2;
    logic [31:0] pdata2;

    // DUT with 0 stall cycles
    logic [31:0] addr0, wdata0, rdata0;
    logic        rd0, wr0, wreq0, berr0, pen0;
    logic [3:0]  be0;
    logic [7:0]  paddr0;
    logic [31:0] pdata0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avalon_stall_ram #(.ADDR_W(8), .STALL_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .address(addr2), .read(rd2), .write(wr2),
        .writedata(wdata2), .byteenable(be2), .waitrequest(wreq2),
        .readdata(rdata2), .bus_error(berr2), .preload_en(pen2),
        .preload_addr(paddr2), .preload_data(pdata2)
    );

    avalon_stall_ram #(.ADDR_W(8), .STALL_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(addr0), .read(rd0), .write(wr0),
        .writedata(wdata0), .byteenable(be0), .waitrequest(wreq0),
        .readdata(rdata0), .bus_error(berr0), .preload_en(pen0),
        .preload_addr(paddr0), .preload_data(pdata0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit d0, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (d0) begin rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd; be0 = be; end
        else    begin rd2 = rd; wr2 = wr; addr2 = a; wdata2 = wd; be2 = be; end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pen2 = 1'b1; paddr2 = a; pdata2 = d;
        @(posedge clk); #1;
        pen2 = 1'b0;
    endtask

    // One bus transfer. Counts cycles until waitrequest=0 and bus_error
    // pulses seen. Optional preload to dut2 on the edge that ends DONE.
    task automatic xfer(input bit d0, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input bit pl, input logic [7:0] pa, input logic [31:0] pd,
                        output int cyc, output int nberr, output logic [31:0] rdat);
        bit done;
        cyc = 0; nberr = 0; done = 0; rdat = 'x;
        drive(d0, rd, wr, a, wd, be);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (d0 ? berr0 : berr2) nberr++;
            if (!(d0 ? wreq0 : wreq2)) begin
                done = 1;
                rdat = d0 ? rdata0 : rdata2;
                if (pl) begin pen2 = 1'b1; paddr2 = pa; pdata2 = pd; end
            end
            @(posedge clk); #1;
        end
        pen2 = 1'b0;
        drive(d0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        chk("xfer_timeout", 32'(done), 32'd1);
    endtask

    int          cyc, nb;
    logic [31:0] rd_v;

    initial begin
        reset = 1'b1;
        pen2 = 0; paddr2 = 0; pdata2 = 0;
        pen0 = 0; paddr0 = 0; pdata0 = 0;
        drive(1'b1, 0, 0, 32'd0, 32'd0, 4'd0);
        drive(1'b0, 1, 0, 32'd0, 32'd0, 4'd0);   // request present during reset

        // Reset state
        @(negedge clk);
        chk("rst_wreq_req", 32'(wreq2), 32'd1);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_berr", 32'(berr2), 32'd0);
        rd2 = 1'b0; #1;
        chk("rst_wreq_noreq", 32'(wreq2), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload then read with 2 stall cycles
        preload(8'd4, 32'h24020010);
        xfer(0, 1, 0, 32'h10, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("s2_read_cycles", 32'(cyc), 32'd4);
        chk("s2_read_data", rd_v, 32'h24020010);
        chk("s2_read_berr", 32'(nb), 32'd0);

        // Zero-stall byte-enable merge
        xfer(1, 0, 1, 32'h20, 32'hDEADBEEF, 4'hF, 0, 0, 0, cyc, nb, rd_v);
        chk("s0_wr1_cycles", 32'(cyc), 32'd2);
        xfer(1, 0, 1, 32'h20, 32'h000000AA, 4'h1, 0, 0, 0, cyc, nb, rd_v);
        chk("s0_wr2_cycles", 32'(cyc), 32'd2);
        xfer(1, 1, 0, 32'h20, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("s0_rd_cycles", 32'(cyc), 32'd2);
        chk("s0_rd_data", rd_v, 32'hDEADBEAA);

        // Read+write together: treated as write, bus_error once
        xfer(0, 1, 1, 32'h08, 32'h70, 4'hF, 0, 0, 0, cyc, nb, rd_v);
        chk("rw_berr_count", 32'(nb), 32'd1);
        chk("rw_cycles", 32'(cyc), 32'd4);
        xfer(0, 1, 0, 32'h08, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("rw_readback", rd_v, 32'h00000070);
        chk("rw_readback_berr", 32'(nb), 32'd0);

        // Misaligned read returns word at index 3
        preload(8'd3, 32'h33330003);
        xfer(0, 1, 0, 32'h0E, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("mis_data", rd_v, 32'h33330003);
        chk("mis_berr_count", 32'(nb), 32'd1);

        // Reset during WAIT of a write to 0x30 aborts the commit
        preload(8'd12, 32'hCAFE0030);
        drive(0, 0, 1, 32'h30, 32'h55555555, 4'hF);
        @(negedge clk);
        chk("rstw_wreq_c0", 32'(wreq2), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_wreq_c1", 32'(wreq2), 32'd1);
        wr2 = 1'b0; reset = 1'b1; #1;
        chk("rstw_wreq", 32'(wreq2), 32'd0);
        chk("rstw_rdata", rdata2, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1, 0, 32'h30, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("rstw_unchanged", rd_v, 32'hCAFE0030);

        // Preload wins over same-edge bus write to the same index
        xfer(0, 0, 1, 32'h20, 32'h22222222, 4'hF, 1, 8'd8, 32'h11111111, cyc, nb, rd_v);
        xfer(0, 1, 0, 32'h20, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("pl_wins", rd_v, 32'h11111111);

        // byteenable=0000 completes but writes nothing
        xfer(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("be0_cycles", 32'(cyc), 32'd4);
        xfer(0, 1, 0, 32'h20, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("be0_nowrite", rd_v, 32'h11111111);

        // Aliasing: upper address bits ignored (0x400 -> index 0 aliases 0x10 only if same index)
        xfer(0, 1, 0, 32'h8000_0010, 0, 4'h0, 0, 0, 0, cyc, nb, rd_v);
        chk("alias_read", rd_v, 32'h24020010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
